// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

  // Receiver frame states; anything other than IDLE means a frame is in flight.
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;

  // Default bit period in clock cycles, shared with the transmitter.
  localparam int DEFAULT_CLOCKS_PER_BIT = 16;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - loadable bit-period down-counter with tick at zero
module uart_bit_timer #(
  parameter int CLOCKS_PER_BIT = 16,
  localparam int W = $clog2(CLOCKS_PER_BIT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         tick
);

  logic [W-1:0] count;

  // Count down to zero and park there; a load takes priority so the owner
  // can re-arm on the very cycle it consumes a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receive deframer, 8N1, mid-bit sampling
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
  input  logic       clkIn,
  input  logic       nResetIn,
  input  logic       rxIn,
  output logic [7:0] dataOut,
  output logic       dataValidOut,
  output logic       frameErrorOut,
  output logic       busyOut
);

  localparam int CW    = $clog2(CLOCKS_PER_BIT);
  localparam int BW    = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(UART_DATA_BITS - 1);

  rx_state_t                  state, state_next;
  logic [BW-1:0]              bit_idx, bit_idx_next;
  logic [UART_DATA_BITS-1:0]  shift_reg, shift_next, data_next;
  logic                       rx_prev;
  logic                       valid_next, error_next;
  logic                       timer_load, tick;
  logic [CW-1:0]              timer_value;
  logic                       start_edge;

  // A falling edge only; a line parked low never looks like a new start.
  assign start_edge = rx_prev & ~rxIn;
  assign busyOut    = (state != IDLE);

  uart_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clkIn),
    .rst_n     (nResetIn),
    .load      (timer_load),
    .load_value(timer_value),
    .tick      (tick)
  );

  // State, shift register, output byte and strobes.
  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      state         <= IDLE;
      bit_idx       <= '0;
      shift_reg     <= '0;
      dataOut       <= '0;
      dataValidOut  <= 1'b0;
      frameErrorOut <= 1'b0;
      rx_prev       <= 1'b1;
    end else begin
      state         <= state_next;
      bit_idx       <= bit_idx_next;
      shift_reg     <= shift_next;
      dataOut       <= data_next;
      dataValidOut  <= valid_next;
      frameErrorOut <= error_next;
      rx_prev       <= rxIn;
    end
  end

  // Next-state logic; the timer is first armed for half a bit so every later
  // full-bit reload lands on a bit centre.
  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    data_next    = dataOut;
    valid_next   = 1'b0;
    error_next   = 1'b0;
    timer_load   = 1'b0;
    timer_value  = FULL_LOAD;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_next  = START;
          timer_load  = 1'b1;
          timer_value = HALF_LOAD;
        end
      end
      START: begin
        if (tick) begin
          if (!rxIn) begin
            state_next   = DATA;
            bit_idx_next = '0;
            timer_load   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_next[bit_idx] = rxIn;
          timer_load          = 1'b1;
          if (bit_idx == LAST_BIT) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + BW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_next = IDLE;
          if (rxIn) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
          end else begin
            error_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a waveform-level model
module tb_uart_rx;

  localparam int C    = 16;
  localparam int H    = C / 2;
  localparam int MAXN = 8192;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data;
  logic       dv, fe, busy;

  uart_rx #(.CLOCKS_PER_BIT(C)) dut (
    .clkIn        (clk),
    .nResetIn     (rst_n),
    .rxIn         (rx),
    .dataOut      (data),
    .dataValidOut (dv),
    .frameErrorOut(fe),
    .busyOut      (busy)
  );

  always #5 clk = ~clk;

  // Stimulus line, one value per clock edge, and expected outputs after each edge.
  logic       line     [MAXN];
  logic       exp_v    [MAXN];
  logic       exp_e    [MAXN];
  logic       exp_b    [MAXN];
  logic [7:0] exp_byte [MAXN];
  logic [7:0] exp_d    [MAXN];
  int         len;

  logic       m_prev = 1'b1;
  logic [7:0] m_data = 8'h00;

  int checks = 0;
  int passes = 0;

  int         done_idx = -1;
  logic       cmp_en   = 1'b0;
  int         seg_valids, seg_errors, first_valid_idx;
  logic [7:0] valid_log[$];

  task automatic lit(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
  endtask

  task automatic push(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      if (len < MAXN) begin
        line[len] = v;
        len++;
      end
    end
  endtask

  task automatic push_frame(input logic [7:0] b, input logic stop);
    push(1'b0, C);
    for (int i = 0; i < 8; i++) push(b[i], C);
    push(stop, C);
  endtask

  // Scan the waveform: find each falling edge, read the line at the nominal
  // sample instants, and mark when busy / the strobe must appear.
  task automatic build_expect();
    int k, e, s;
    logic p;
    logic [7:0] b, d;
    for (int i = 0; i < len; i++) begin
      exp_v[i] = 1'b0; exp_e[i] = 1'b0; exp_b[i] = 1'b0; exp_byte[i] = 8'h00;
    end
    k = 0;
    while (k < len) begin
      p = (k == 0) ? m_prev : line[k-1];
      if (p && !line[k]) begin
        e = k;
        if (e + H >= len) begin
          for (int i = e; i < len; i++) exp_b[i] = 1'b1;
          break;
        end
        if (line[e+H]) begin
          for (int i = e; i < e + H; i++) exp_b[i] = 1'b1;
          k = e + H + 1;
          continue;
        end
        s = e + H + 9 * C;
        if (s >= len) begin
          for (int i = e; i < len; i++) exp_b[i] = 1'b1;
          break;
        end
        for (int i = 0; i < 8; i++) b[i] = line[e + H + (i + 1) * C];
        for (int i = e; i < s; i++) exp_b[i] = 1'b1;
        if (line[s]) begin
          exp_v[s] = 1'b1;
          exp_byte[s] = b;
        end else begin
          exp_e[s] = 1'b1;
        end
        k = s + 1;
      end else begin
        k++;
      end
    end
    d = m_data;
    for (int i = 0; i < len; i++) begin
      if (exp_v[i]) d = exp_byte[i];
      exp_d[i] = d;
    end
  endtask

  task automatic run_segment();
    build_expect();
    seg_valids = 0;
    seg_errors = 0;
    first_valid_idx = -1;
    valid_log.delete();
    done_idx = -1;
    cmp_en = 1'b1;
    for (int n = 0; n < len; n++) begin
      rx = line[n];
      @(posedge clk);
      #1;
      done_idx = n;
    end
    @(negedge clk);
    #1;
    cmp_en = 1'b0;
    m_data = exp_d[len-1];
    m_prev = line[len-1];
  endtask

  // Every cycle of a segment: outputs after edge done_idx against the model.
  always @(negedge clk) begin
    if (cmp_en && done_idx >= 0) begin
      checks++;
      if ({dv, fe, busy, data} === {exp_v[done_idx], exp_e[done_idx], exp_b[done_idx], exp_d[done_idx]})
        passes++;
      else
        $display("FAIL cycle %0d: got valid=%b err=%b busy=%b data=%h, expected valid=%b err=%b busy=%b data=%h",
                 done_idx, dv, fe, busy, data,
                 exp_v[done_idx], exp_e[done_idx], exp_b[done_idx], exp_d[done_idx]);
      if (dv === 1'b1) begin
        seg_valids++;
        valid_log.push_back(data);
        if (first_valid_idx < 0) first_valid_idx = done_idx;
      end
      if (fe === 1'b1) seg_errors++;
    end
  end

  initial begin
    // Reset state.
    #2;
    lit("reset data", int'(data), 0);
    lit("reset valid", int'(dv), 0);
    lit("reset error", int'(fe), 0);
    lit("reset busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single frame 0x55: edge at index 10, strobe after edge 10+H+9C = 162.
    len = 0;
    push(1'b1, 10); push_frame(8'h55, 1'b1); push(1'b1, 20);
    run_segment();
    lit("model strobe index", int'(exp_v[162]), 1);
    lit("55 strobe index", first_valid_idx, 162);
    lit("55 valid count", seg_valids, 1);
    lit("55 error count", seg_errors, 0);
    lit("55 data", int'(data), 8'h55);

    // Back-to-back frames, next start half a bit after the stop sample.
    len = 0;
    push(1'b1, 5); push_frame(8'hA3, 1'b1); push_frame(8'h0F, 1'b1); push(1'b1, 20);
    run_segment();
    lit("b2b valid count", seg_valids, 2);
    lit("b2b first byte", (valid_log.size() > 0) ? int'(valid_log[0]) : -1, 8'hA3);
    lit("b2b second byte", (valid_log.size() > 1) ? int'(valid_log[1]) : -1, 8'h0F);

    // Idle-line glitch of 3 cycles.
    len = 0;
    push(1'b1, 5); push(1'b0, 3); push(1'b1, 30);
    run_segment();
    lit("glitch busy model", int'(exp_b[5 + H - 1]), 1);
    lit("glitch valid count", seg_valids, 0);
    lit("glitch error count", seg_errors, 0);
    lit("glitch data kept", int'(data), 8'h0F);

    // Framing error into a 40-bit break, then recovery with 0x81.
    len = 0;
    push(1'b1, 5); push_frame(8'h3C, 1'b0); push(1'b0, 40 * C);
    push(1'b1, 10); push_frame(8'h81, 1'b1); push(1'b1, 20);
    run_segment();
    lit("break error count", seg_errors, 1);
    lit("break valid count", seg_valids, 1);
    lit("break recovery byte", (valid_log.size() > 0) ? int'(valid_log[0]) : -1, 8'h81);

    // Reset in the middle of data bit 4.
    len = 0;
    push(1'b1, 5); push(1'b0, C);
    for (int i = 0; i < 4; i++) push(i[0], C);
    push(1'b1, H);
    run_segment();
    lit("pre-reset no strobe", seg_valids + seg_errors, 0);
    #2 rst_n = 1'b0;
    #1;
    lit("abort data", int'(data), 0);
    lit("abort valid", int'(dv), 0);
    lit("abort error", int'(fe), 0);
    lit("abort busy", int'(busy), 0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    m_data = 8'h00;
    m_prev = 1'b1;
    len = 0;
    push(1'b1, 5); push_frame(8'hC6, 1'b1); push(1'b1, 20);
    run_segment();
    lit("post-reset byte", (valid_log.size() > 0) ? int'(valid_log[0]) : -1, 8'hC6);

    // LSB-first.
    len = 0;
    push(1'b1, 5); push_frame(8'h01, 1'b1); push(1'b1, 20);
    run_segment();
    lit("lsb first data", int'(data), 8'h01);

    // Randomised frames, gaps, glitches and bad stop bits.
    len = 0;
    push(1'b1, 5);
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        push(1'b0, $urandom_range(1, H - 1));
        push(1'b1, $urandom_range(H, 30));
      end
      push_frame(8'($urandom_range(0, 255)), $urandom_range(0, 4) != 0);
      push(1'b1, $urandom_range(0, 40));
    end
    push(1'b1, 12 * C);
    run_segment();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive deframer sitting directly downstream of the RX majority-3 glitch filter. It consumes the filtered, idle-high serial line and detects start bits. It samples 8 data bits LSB-first at mid-bit plus one stop bit, then emits each byte with a single-cycle valid strobe, or flags a framing error.

## Interface
Parameters:
- CLOCKS_PER_BIT, 16, clkIn cycles per bit period; must be ≥ 4 and even.

Ports:
- clkIn  input  1  sole clock; all state on its rising edge.
- nResetIn  input  1  reset, asynchronous and active-low.
- rxIn  input  1  filtered serial line from the majority filter; idle high; synchronous to clkIn.
- dataOut  output  8  last correctly received byte; holds its value until the next good frame.
- dataValidOut  output  1  one-cycle pulse when dataOut has just been updated.
- frameErrorOut  output  1  one-cycle pulse when the stop bit was sampled low.
- busyOut  output  1  high while a frame is in progress (any state other than IDLE).

## Operation
- The clock is clkIn only. nResetIn is asynchronous and active-low. With nResetIn low, all registers take their reset values immediately.
- Reset values: dataOut=0x00, dataValidOut=0, frameErrorOut=0, busyOut=0, state=IDLE, bit counter=0, cycle counter=0, rxPrev=1.
- rxPrev holds the rxIn value from the previous cycle. A start edge is the condition rxPrev=1 and rxIn=0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a start edge, go to START and load the cycle counter. A line held low does not retrigger.
  - START: at the start-bit midpoint, check rxIn.
    - rxIn=0: go to DATA with bit index 0.
    - rxIn=1: treat as a glitch and return to IDLE with no output.
  - DATA: every CLOCKS_PER_BIT cycles, shift rxIn into bit[index] (LSB first). After bit 7, go to STOP.
  - STOP: at the stop-bit midpoint, sample rxIn.
    - rxIn=1: dataOut ← shift register and pulse dataValidOut.
    - rxIn=0: pulse frameErrorOut; dataOut is unchanged.
    - In both cases return to IDLE on the same edge. Do not wait for the end of the stop bit, so a start edge arriving half a bit later is still caught.
- dataValidOut and frameErrorOut are never high in the same cycle. Each is high for exactly one cycle per frame.
- Reset asserted mid-frame aborts the frame: no strobe, and outputs return to their reset values. Note that dataOut is cleared to 0x00.

## Timing
- Let edge E be the clock edge at which the start edge is seen (rxPrev=1, rxIn=0). Let H = CLOCKS_PER_BIT/2 and C = CLOCKS_PER_BIT.
- Sample points:
  - Start bit re-check at edge E+H.
  - Data bit i (i = 0..7) sampled at edge E+H+(i+1)·C.
  - Stop bit sampled at edge E+H+9·C.
- The result strobe (valid or error) is registered. It is high for the one cycle following edge E+H+9·C, and dataOut changes on that same edge.
- busyOut is high from edge E+1 until the stop-sample edge. It is low again in the cycle the strobe is high.
- The cycle counter width is $clog2(CLOCKS_PER_BIT). It counts down to 0, and reloads to C−1 at each sample point.
- With C=16, the latency from line falling to dataValidOut is about 152 cycles plus the filter's two cycles.

## Structure
- Package uart_pkg holds:
  - enum rx_state_t {IDLE, START, DATA, STOP};
  - localparam UART_DATA_BITS = 8;
  - the shared default CLOCKS_PER_BIT = 16, for reuse by the TX side.
- One natural sub-module, uart_bit_timer: a loadable down-counter with a "tick at zero" output, parameterised by CLOCKS_PER_BIT. It is reusable by uart_tx. Everything else stays in uart_rx.

## Test plan
All scenarios use CLOCKS_PER_BIT=16 and drive rxIn directly with an ideal bit-period stimulus.
- Frame 0x55, stop=1 → dataOut=0x55 with a one-cycle dataValidOut at E+H+9C+1; frameErrorOut stays 0; busyOut drops on the same edge.
- Back-to-back frames 0xA3 then 0x0F, the next start edge half a bit after the stop sample → two valid pulses with dataOut 0xA3 then 0x0F, none missed.
- Idle-line glitch, rxIn low for 3 cycles then high → busyOut high until E+H, then IDLE; no valid and no error.
- Frame 0x3C with stop=0 and rxIn then held low for 40 bit times (break) → one frameErrorOut pulse; dataOut keeps its previous value; no retrigger until rxIn goes high then low, after which the next frame 0x81 is received correctly.
- nResetIn pulsed low during data bit 4 of a frame → all outputs 0 immediately, state IDLE, no strobe; a fresh frame 0xC6 after release is received correctly.
- LSB-first check: frame 0x01 → only the bit sampled first is set, dataOut=0x01.
